sd_cmd_responder: RTL and testbench

- Card-side endpoint of the SD CMD line, used as an in-fabric card emulator for host bring-up and loopback tests.
- Oversamples host SDCLK in the clk_i domain and deserialises 48-bit host commands sampled on SDCLK rising edges.
- Checks CRC7 and decodes the command index.
- Serialises the matching R1/R3/R7 response on SDCLK falling edges, driving CMD through an output enable.

---
 rtl/sd_pkg.sv | 14 +
 rtl/sd_crc7.sv | 18 +
 rtl/sd_cmd_responder.sv | 122 ++++++++++++
 tb/tb_sd_cmd_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: SD CMD-line command indices, CRC7 polynomial, frame length and FSM/response enums
package sd_pkg;
  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD2  = 6'd2;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD9  = 6'd9;
  localparam logic [5:0] CMD10 = 6'd10;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int FRAME_LEN = 48;
  typedef enum logic [1:0] {NONE, R1, R3, R7} rsp_t;
  typedef enum logic [2:0] {IDLE, RX, CHECK, NCR, TX} state_t;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), one bit per enable, synchronous clear
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);
  logic [6:0] crc_q, crc_d;
  always_comb crc_d = clr_i ? 7'h00 : en_i ? ({crc_q[5:0], 1'b0} ^ ((din_i ^ crc_q[6]) ? CRC7_POLY : 7'h00)) : crc_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) crc_q <= '0;
    else crc_q <= crc_d;
  assign crc_o = crc_q;
endmodule

// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: SD CMD-line card emulator answering R1/R3/R7 on SDCLK falls.
// Define SD_CMD_RESPONDER_CRC_CHECK_EN to drop frames whose CRC7 mismatches (pulses crc_err_o).
module sd_cmd_responder
  import sd_pkg::*;
#(
  parameter int         NCR_CYCLES    = 2,
  parameter logic [3:0] VHS_SUPPORTED = 4'b0001
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sdclk_i,
  input  logic        cmd_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  input  logic [31:0] card_status_i,
  input  logic [31:0] ocr_i,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        crc_err_o,
  output logic        busy_o
);
  localparam logic [6:0] NCR_LAST = 7'(NCR_CYCLES - 1);
  state_t state_q, state_d;
  rsp_t rsp_q, rsp_d, rsp_sel;
  logic [1:0] sck_sync_q, cmd_sync_q;
  logic sck_prev_q;
  logic [FRAME_LEN-1:0] sh_q, sh_d, rsp_frame;
  logic [6:0] cnt_q, cnt_d, tx_crc;
  logic [5:0] idx_q, idx_d, rx_idx;
  logic [31:0] arg_q, arg_d, rx_arg;
  logic app_q, app_d, cmd_q, cmd_d, oe_q, oe_d, valid_q, valid_d, err_q, err_d;
  logic rise, fall, cmd_s, framed, crc_bad, accept, tx_bit;
  assign cmd_s  = cmd_sync_q[1];
  assign rise   = sck_sync_q[1] & ~sck_prev_q;
  assign fall   = ~sck_sync_q[1] & sck_prev_q;
  assign rx_idx = sh_q[45:40];
  assign rx_arg = sh_q[39:8];
  assign framed = sh_q[46] & sh_q[0];
`ifdef SD_CMD_RESPONDER_CRC_CHECK_EN
  logic [6:0] rx_crc;
  sd_crc7 u_rx_crc (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(state_q == IDLE),
    .en_i(state_q == RX && rise && cnt_q < 7'd40), .din_i(cmd_s), .crc_o(rx_crc)
  );
  assign crc_bad = rx_crc != sh_q[7:1];
`else
  assign crc_bad = 1'b0;
`endif
  assign accept = framed & ~crc_bad;
  // CRC is accumulated while bits 47..8 go out, so it is ready by bit 40
  sd_crc7 u_tx_crc (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(state_q != TX),
    .en_i(state_q == TX && fall && cnt_q < 7'd40), .din_i(sh_q[47]), .crc_o(tx_crc)
  );
  assign rsp_sel = (rx_idx == CMD0 || rx_idx == CMD2 || rx_idx == CMD9 || rx_idx == CMD10) ? NONE :
                   (rx_idx == CMD8) ? ((rx_arg[11:8] == VHS_SUPPORTED) ? R7 : NONE) :
                   (rx_idx == CMD41 && app_q) ? R3 : R1;
  assign rsp_frame = (rsp_sel == R7) ? {2'b00, CMD8, 20'd0, rx_arg[11:0], 8'hFF} :
                     (rsp_sel == R3) ? {2'b00, 6'h3F, ocr_i, 8'hFF} :
                                       {2'b00, rx_idx, card_status_i, 8'hFF};
  assign tx_bit = (rsp_q != R3 && cnt_q >= 7'd40 && cnt_q <= 7'd46) ? tx_crc[3'd6 - cnt_q[2:0]] : sh_q[47];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE; rsp_q <= NONE; sck_sync_q <= '0; sck_prev_q <= 1'b0; cmd_sync_q <= '1;
      sh_q <= '0; cnt_q <= '0; idx_q <= '0; arg_q <= '0; app_q <= 1'b0;
      cmd_q <= 1'b1; oe_q <= 1'b0; valid_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; rsp_q <= rsp_d; sck_sync_q <= {sck_sync_q[0], sdclk_i};
      sck_prev_q <= sck_sync_q[1]; cmd_sync_q <= {cmd_sync_q[0], cmd_i};
      sh_q <= sh_d; cnt_q <= cnt_d; idx_q <= idx_d; arg_q <= arg_d; app_q <= app_d;
      cmd_q <= cmd_d; oe_q <= oe_d; valid_q <= valid_d; err_q <= err_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise && !cmd_s) state_d = RX;
      RX:      if (rise && cnt_q == 7'd47) state_d = CHECK;
      CHECK:   state_d = (accept && rsp_sel != NONE) ? NCR : IDLE;
      NCR:     if (fall && cnt_q == NCR_LAST) state_d = TX;
      TX:      if (fall && cnt_q == 7'd48) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    sh_d = sh_q; cnt_d = cnt_q; idx_d = idx_q; arg_d = arg_q; app_d = app_q; rsp_d = rsp_q;
    cmd_d = cmd_q; oe_d = oe_q; valid_d = 1'b0; err_d = 1'b0;
    case (state_q)
      IDLE: if (rise && !cmd_s) begin
        sh_d = {sh_q[46:0], cmd_s};
        cnt_d = 7'd1;
      end
      RX: if (rise) begin
        sh_d = {sh_q[46:0], cmd_s};
        cnt_d = cnt_q + 7'd1;
      end
      CHECK: begin
        cnt_d = '0;
        valid_d = accept;
        err_d = framed & crc_bad;
        if (accept) begin
          idx_d = rx_idx; arg_d = rx_arg; app_d = rx_idx == CMD55; rsp_d = rsp_sel; sh_d = rsp_frame;
        end
      end
      NCR: if (fall) cnt_d = (cnt_q == NCR_LAST) ? '0 : cnt_q + 7'd1;
      TX: if (fall) begin
        oe_d = cnt_q != 7'd48;
        cmd_d = (cnt_q == 7'd48) ? 1'b1 : tx_bit;
        sh_d = {sh_q[46:0], 1'b0};
        cnt_d = cnt_q + 7'd1;
      end
      default: ;
    endcase
  end
  assign cmd_o       = cmd_q;
  assign cmd_oe_o    = oe_q;
  assign cmd_valid_o = valid_q;
  assign cmd_index_o = idx_q;
  assign cmd_arg_o   = arg_q;
  assign crc_err_o   = err_q;
  assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb_sd_cmd_responder: host-side bench driving SD commands and checking responses against a reference model
module tb_sd_cmd_responder;
  localparam int NCR = 2;
  localparam bit CRC_CHK =
`ifdef SD_CMD_RESPONDER_CRC_CHECK_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, sdclk = 1'b1, cmd_i = 1'b1;
  logic [31:0] status = '0, ocr = '0;
  logic cmd_o, cmd_oe_o, cmd_valid_o, crc_err_o, busy_o;
  logic [5:0] cmd_index_o;
  logic [31:0] cmd_arg_o;
  int total = 0, bad = 0, half = 6;
  int valid_cnt = 0, err_cnt = 0, oe_cnt = 0;
  logic ref_app = 1'b0;
  logic [5:0] ref_idx = '0;
  logic [31:0] ref_arg = '0;

  sd_cmd_responder #(.NCR_CYCLES(NCR), .VHS_SUPPORTED(4'b0001)) dut (
    .clk_i(clk), .rst_i(rst), .sdclk_i(sdclk), .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe_o(cmd_oe_o),
    .card_status_i(status), .ocr_i(ocr), .cmd_valid_o(cmd_valid_o), .cmd_index_o(cmd_index_o),
    .cmd_arg_o(cmd_arg_o), .crc_err_o(crc_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (cmd_valid_o) valid_cnt++;
    if (crc_err_o) err_cnt++;
    if (cmd_oe_o) oe_cnt++;
  end

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c = '0;
    for (int i = 39; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
    return c;
  endfunction

  function automatic logic [47:0] mk(input logic [5:0] i, input logic [31:0] a, input logic corrupt);
    logic [39:0] h = {2'b01, i, a};
    return {h, crc7(h) ^ (corrupt ? 7'h01 : 7'h00), 1'b1};
  endfunction

  // {response expected, response frame} for an accepted command
  function automatic logic [48:0] model(input logic [5:0] i, input logic [31:0] a, input logic app);
    logic [39:0] h;
    if (i == 0 || i == 2 || i == 9 || i == 10) return '0;
    if (i == 8) begin
      if (a[11:8] != 4'b0001) return '0;
      h = {2'b00, 6'd8, 20'd0, a[11:0]};
      return {1'b1, h, crc7(h), 1'b1};
    end
    if (i == 41 && app) return {1'b1, 2'b00, 6'h3F, ocr, 8'hFF};
    h = {2'b00, i, status};
    return {1'b1, h, crc7(h), 1'b1};
  endfunction

  task automatic sd_cycle(input logic b, output logic oe, output logic c);
    sdclk = 1'b0; cmd_i = b;
    repeat (half) @(negedge clk);
    oe = cmd_oe_o; c = cmd_o;
    sdclk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic xfer(input logic [47:0] f, output logic got, output logic [47:0] r, output int st,
                      output logic rel, output int dv, output int de, output int doe);
    int v0 = valid_cnt, e0 = err_cnt, o0 = oe_cnt, n = 0;
    logic o, c;
    r = '0; st = 0; rel = 1'b0;
    for (int i = 47; i >= 0; i--) sd_cycle(f[i], o, c);
    for (int j = 1; j <= NCR + 52; j++) begin
      sd_cycle(1'b1, o, c);
      if (o === 1'b1 && n < 48) begin
        if (n == 0) st = j;
        r = {r[46:0], c};
        n++;
      end else if (n == 48 && j == st + 48) rel = (o === 1'b0 && c === 1'b1);
    end
    got = n > 0; dv = valid_cnt - v0; de = err_cnt - e0; doe = oe_cnt - o0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_o, cmd_oe_o, cmd_valid_o, crc_err_o, busy_o, cmd_index_o, cmd_arg_o} !== {5'b10000, 38'd0}) begin
      bad++; $display("FAIL reset_in: got %b/%b/%b/%b/%b idx=%h arg=%h want 1/0/0/0/0 idx=0 arg=0",
                      cmd_o, cmd_oe_o, cmd_valid_o, crc_err_o, busy_o, cmd_index_o, cmd_arg_o);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({cmd_o, cmd_oe_o, busy_o} !== 3'b100) begin
      bad++; $display("FAIL reset_out: cmd/oe/busy got %b%b%b want 100", cmd_o, cmd_oe_o, busy_o);
    end
  endtask

  task automatic test_cmd0_slow;
    logic got, rel; logic [47:0] r; int st, dv, de, doe;
    half = 125;
    xfer(48'h400000000095, got, r, st, rel, dv, de, doe);
    half = 6;
    total++; if (dv !== 1) begin bad++; $display("FAIL cmd0_valid: got %0d pulses want 1", dv); end
    total++; if (cmd_index_o !== 6'd0) begin bad++; $display("FAIL cmd0_index: got %0d want 0", cmd_index_o); end
    total++; if (doe !== 0) begin bad++; $display("FAIL cmd0_oe: oe high %0d cycles want 0", doe); end
  endtask

  task automatic test_cmd8;
    logic got, rel; logic [47:0] r; int st, dv, de, doe;
    xfer(48'h48000001AA87, got, r, st, rel, dv, de, doe);
    total++; if (dv !== 1) begin bad++; $display("FAIL cmd8_valid: got %0d want 1", dv); end
    total++; if (r !== 48'h08000001AA13) begin bad++; $display("FAIL cmd8_r7: got %h want 08000001aa13", r); end
    total++; if (st !== NCR + 1) begin bad++; $display("FAIL cmd8_ncr: start at fall %0d want %0d", st, NCR + 1); end
    total++; if (rel !== 1'b1) begin bad++; $display("FAIL cmd8_release: got %b want 1", rel); end
    total++; if ({cmd_index_o, cmd_arg_o} !== {6'd8, 32'h1AA}) begin
      bad++; $display("FAIL cmd8_latch: got %0d/%h want 8/000001aa", cmd_index_o, cmd_arg_o);
    end
  endtask

  task automatic test_cmd8_bad_vhs;
    logic got, rel; logic [47:0] r; int st, dv, de, doe;
    xfer(mk(6'd8, 32'h2AA, 1'b0), got, r, st, rel, dv, de, doe);
    total++; if (dv !== 1) begin bad++; $display("FAIL vhs_valid: got %0d want 1", dv); end
    total++; if (got !== 1'b0) begin bad++; $display("FAIL vhs_noresp: got response %h want none", r); end
    total++; if (cmd_arg_o !== 32'h2AA) begin bad++; $display("FAIL vhs_arg: got %h want 000002aa", cmd_arg_o); end
  endtask

  task automatic test_acmd41;
    logic got, rel; logic [47:0] r, e; int st, dv, de, doe;
    status = 32'h00000120; ocr = 32'hC0FF8000;
    e = {2'b00, 6'd55, status, crc7({2'b00, 6'd55, status}), 1'b1};
    xfer(mk(6'd55, 32'h0, 1'b0), got, r, st, rel, dv, de, doe);
    total++; if (r !== e) begin bad++; $display("FAIL cmd55_r1: got %h want %h", r, e); end
    xfer(mk(6'd41, 32'h40300000, 1'b0), got, r, st, rel, dv, de, doe);
    total++; if (r !== 48'h3FC0FF8000FF) begin bad++; $display("FAIL acmd41_r3: got %h want 3fc0ff8000ff", r); end
    total++; if (rel !== 1'b1) begin bad++; $display("FAIL acmd41_release: got %b want 1", rel); end
  endtask

  task automatic test_crc_err;
    logic got, rel; logic [47:0] r; int st, dv, de, doe;
    xfer(48'h48000001AA85, got, r, st, rel, dv, de, doe);
    if (CRC_CHK) begin
      total++; if (de !== 1) begin bad++; $display("FAIL crc_err_pulse: got %0d want 1", de); end
      total++; if (dv !== 0) begin bad++; $display("FAIL crc_err_valid: got %0d want 0", dv); end
      total++; if (got !== 1'b0) begin bad++; $display("FAIL crc_err_noresp: got %h want none", r); end
      total++; if (cmd_index_o !== 6'd41) begin bad++; $display("FAIL crc_err_index: got %0d want 41", cmd_index_o); end
    end else begin
      total++; if (de !== 0) begin bad++; $display("FAIL crc_ign_err: got %0d want 0", de); end
      total++; if (dv !== 1) begin bad++; $display("FAIL crc_ign_valid: got %0d want 1", dv); end
      total++; if (r !== 48'h08000001AA13) begin bad++; $display("FAIL crc_ign_r7: got %h want 08000001aa13", r); end
      total++; if (cmd_index_o !== 6'd8) begin bad++; $display("FAIL crc_ign_index: got %0d want 8", cmd_index_o); end
    end
    ref_app = 1'b0;
    ref_idx = CRC_CHK ? 6'd41 : 6'd8;
    ref_arg = CRC_CHK ? 32'h40300000 : 32'h1AA;
  endtask

  task automatic test_random;
    logic [5:0] pool [0:13];
    logic [5:0] idx; logic [31:0] arg; logic corrupt, acc, got, rel, eg; logic [47:0] r; logic [48:0] e;
    int st, dv, de, doe;
    pool = '{6'd0, 6'd2, 6'd8, 6'd8, 6'd41, 6'd55, 6'd55, 6'd17, 6'd13, 6'd6, 6'd9, 6'd10, 6'd24, 6'd41};
    for (int k = 0; k < 16; k++) begin
      idx = pool[$urandom_range(13)];
      arg = $urandom;
      if (idx == 6'd8 && $urandom_range(1) == 1) arg[11:8] = 4'b0001;
      status = $urandom; ocr = $urandom;
      corrupt = $urandom_range(3) == 0;
      acc = !(corrupt && CRC_CHK);
      e = model(idx, arg, ref_app);
      eg = acc && e[48];
      xfer(mk(idx, arg, corrupt), got, r, st, rel, dv, de, doe);
      if (acc) begin ref_app = idx == 6'd55; ref_idx = idx; ref_arg = arg; end
      total++; if (dv !== int'(acc)) begin bad++; $display("FAIL rnd%0d_valid cmd%0d: got %0d want %0d", k, idx, dv, acc); end
      total++; if (de !== int'(corrupt && CRC_CHK)) begin bad++; $display("FAIL rnd%0d_err: got %0d want %0d", k, de, corrupt && CRC_CHK); end
      total++; if (got !== eg) begin bad++; $display("FAIL rnd%0d_resp cmd%0d: got %b want %b", k, idx, got, eg); end
      if (eg) begin
        total++;
        if (r !== e[47:0] || st !== NCR + 1 || rel !== 1'b1) begin
          bad++; $display("FAIL rnd%0d_frame cmd%0d: got %h st=%0d rel=%b want %h st=%0d rel=1", k, idx, r, st, rel, e[47:0], NCR + 1);
        end
      end
      total++;
      if ({cmd_index_o, cmd_arg_o} !== {ref_idx, ref_arg}) begin
        bad++; $display("FAIL rnd%0d_latch: got %0d/%h want %0d/%h", k, cmd_index_o, cmd_arg_o, ref_idx, ref_arg);
      end
    end
  endtask

  task automatic test_reset_mid_tx;
    logic o, c, got, rel; logic [47:0] f, r; int n = 0, st, dv, de, doe;
    f = mk(6'd8, 32'h1AA, 1'b0);
    for (int i = 47; i >= 0; i--) sd_cycle(f[i], o, c);
    for (int j = 0; j < NCR + 30 && n < 20; j++) begin
      sd_cycle(1'b1, o, c);
      if (o === 1'b1) n++;
    end
    total++; if (n !== 20) begin bad++; $display("FAIL midrst_reach: got %0d bits want 20", n); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({cmd_oe_o, cmd_o, busy_o} !== 3'b010) begin
      bad++; $display("FAIL midrst_release: oe/cmd/busy got %b%b%b want 010", cmd_oe_o, cmd_o, busy_o);
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    xfer(48'h400000000095, got, r, st, rel, dv, de, doe);
    total++; if (dv !== 1 || cmd_index_o !== 6'd0) begin
      bad++; $display("FAIL midrst_cmd0: got %0d pulses idx %0d want 1 idx 0", dv, cmd_index_o);
    end
    total++; if (got !== 1'b0) begin bad++; $display("FAIL midrst_noresp: got %h want none", r); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_cmd0_slow();
    test_cmd8();
    test_cmd8_bad_vhs();
    test_acmd41();
    test_crc_err();
    test_random();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
